// File: rtl/tlk2711_pkg.sv
// Character constants, word classes and receive states shared by the tlk2711 TX and RX blocks.
package tlk2711_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    localparam logic [15:0] IDLE_WORD = {D5_6, K28_5};
    localparam logic [15:0] SOF_WORD  = {K27_7, K27_7};
    localparam logic [15:0] EOF_WORD  = {K29_7, K29_7};

    typedef enum logic [2:0] {
        WC_IDLE,
        WC_SOF,
        WC_EOF,
        WC_DATA,
        WC_BAD
    } word_class_t;

    typedef enum logic [1:0] {
        ST_UNSYNC,
        ST_IDLE,
        ST_FRAME,
        ST_DISCARD
    } rx_state_t;

    function automatic word_class_t classify(input logic [15:0] rxd,
                                             input logic        kmsb,
                                             input logic        klsb);
        word_class_t c;
        case ({kmsb, klsb})
            2'b00:   c = WC_DATA;
            2'b01:   c = (rxd == IDLE_WORD) ? WC_IDLE : WC_BAD;
            2'b11:   c = (rxd == SOF_WORD) ? WC_SOF :
                         (rxd == EOF_WORD) ? WC_EOF : WC_BAD;
            default: c = WC_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tlk2711_rx_frame_pat_chk.sv
// Incrementing-pattern checker for the decoded payload stream; counts words
// that differ from the previous word + 1 within a frame.
module tlk2711_pat_chk #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             sof,
    input  logic [15:0]      data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [15:0] exp_q;

    // Both a match and a mismatch resync the expectation to the received word + 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q   <= '0;
            err_cnt <= '0;
        end else begin
            if (valid)
                exp_q <= data + 16'd1;
            if (clr_cnt)
                err_cnt <= '0;
            else if (valid && !sof && (data != exp_q) && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tlk2711_rx_frame.sv
// TLK2711 receive lane: word lock on idles, SOF/EOF frame delineation, error counters.
// Build option TLK2711_RX_PAT_CHECK_EN enables the payload pattern checker.
module tlk2711_rx_frame
    import tlk2711_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      i_rxd,
    input  logic             i_rklsb,
    input  logic             i_rkmsb,
    input  logic             i_clr_cnt,
    output logic             o_lock,
    output logic [15:0]      o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_pat_err_cnt
);

    localparam int unsigned WC_W  = $clog2(MAX_WORDS + 1);
    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [WC_W-1:0]  WORD_MAX = WC_W'(MAX_WORDS);
    localparam logic [WC_W-1:0]  WORD_ONE = WC_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);

    word_class_t      wclass;
    rx_state_t        state;
    logic [RUN_W-1:0] run_cnt;
    logic [WC_W-1:0]  word_cnt;
    logic [15:0]      buf_data;

    logic             lock_r, valid_r, sof_r, eof_r, ferr_r;
    logic [15:0]      data_r;
    logic [CNT_W-1:0] frame_cnt_r, err_cnt_r;

    logic             emit, emit_eof, err_evt, good_evt;

    assign wclass = classify(i_rxd, i_rkmsb, i_rklsb);

    // word_cnt doubles as the buffer-occupied flag: non-zero means the
    // buffer holds payload word number word_cnt of the current frame.
    always_comb begin
        emit     = 1'b0;
        emit_eof = 1'b0;
        err_evt  = 1'b0;
        good_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wclass == WC_DATA || wclass == WC_EOF)
                    err_evt = 1'b1;
            end
            ST_FRAME: begin
                case (wclass)
                    WC_DATA: begin
                        if (word_cnt == WORD_MAX) begin
                            err_evt  = 1'b1;
                            emit     = 1'b1;
                            emit_eof = 1'b1;
                        end else begin
                            emit = (word_cnt != '0);
                        end
                    end
                    WC_EOF: begin
                        if (word_cnt != '0) begin
                            emit     = 1'b1;
                            emit_eof = 1'b1;
                            good_evt = 1'b1;
                        end else begin
                            err_evt = 1'b1;
                        end
                    end
                    default: begin
                        err_evt  = 1'b1;
                        emit     = (word_cnt != '0);
                        emit_eof = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_UNSYNC;
            run_cnt     <= '0;
            word_cnt    <= '0;
            buf_data    <= '0;
            lock_r      <= 1'b0;
            valid_r     <= 1'b0;
            sof_r       <= 1'b0;
            eof_r       <= 1'b0;
            ferr_r      <= 1'b0;
            data_r      <= '0;
            frame_cnt_r <= '0;
            err_cnt_r   <= '0;
        end else begin
            valid_r <= emit;
            sof_r   <= emit && (word_cnt == WORD_ONE);
            eof_r   <= emit && emit_eof;
            ferr_r  <= err_evt;
            if (emit)
                data_r <= buf_data;

            if (i_clr_cnt) begin
                frame_cnt_r <= '0;
                err_cnt_r   <= '0;
            end else begin
                if (good_evt && frame_cnt_r != '1)
                    frame_cnt_r <= frame_cnt_r + 1'b1;
                if (err_evt && err_cnt_r != '1)
                    err_cnt_r <= err_cnt_r + 1'b1;
            end

            if (state == ST_UNSYNC) begin
                if (wclass != WC_IDLE) begin
                    run_cnt <= '0;
                end else if (run_cnt == RUN_LAST) begin
                    state   <= ST_IDLE;
                    lock_r  <= 1'b1;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else if (wclass == WC_BAD && run_cnt == RUN_LAST) begin
                state   <= ST_UNSYNC;
                lock_r  <= 1'b0;
                run_cnt <= '0;
            end else begin
                run_cnt <= (wclass == WC_BAD) ? run_cnt + 1'b1 : '0;
                case (state)
                    ST_IDLE: begin
                        if (wclass == WC_SOF) begin
                            state    <= ST_FRAME;
                            word_cnt <= '0;
                        end
                    end
                    ST_FRAME: begin
                        case (wclass)
                            WC_DATA: begin
                                if (word_cnt == WORD_MAX) begin
                                    state <= ST_DISCARD;
                                end else begin
                                    buf_data <= i_rxd;
                                    word_cnt <= word_cnt + 1'b1;
                                end
                            end
                            WC_SOF:  word_cnt <= '0;
                            default: state <= ST_IDLE;
                        endcase
                    end
                    ST_DISCARD: begin
                        if (wclass == WC_EOF || wclass == WC_IDLE) begin
                            state <= ST_IDLE;
                        end else if (wclass == WC_SOF) begin
                            state    <= ST_FRAME;
                            word_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_lock      = lock_r;
    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_sof       = sof_r;
    assign o_eof       = eof_r;
    assign o_frame_err = ferr_r;
    assign o_frame_cnt = frame_cnt_r;
    assign o_err_cnt   = err_cnt_r;

`ifdef TLK2711_RX_PAT_CHECK_EN
    tlk2711_pat_chk #(
        .CNT_W (CNT_W)
    ) u_pat_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid_r),
        .sof     (sof_r),
        .data    (data_r),
        .clr_cnt (i_clr_cnt),
        .err_cnt (o_pat_err_cnt)
    );
`else
    assign o_pat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_tlk2711_rx_frame.sv
// Scoreboard bench for tlk2711_rx_frame: frame-level reference model feeds an
// expected-event queue, a monitor pops on every output beat or error pulse.
module tb_tlk2711_rx_frame;

    localparam int unsigned MAX_WORDS = 1024;
    localparam int unsigned LOCK_CNT  = 4;
    localparam int unsigned CNT_W     = 8;
    localparam longint      CNT_MAX   = (longint'(1) << CNT_W) - 1;
`ifdef TLK2711_RX_PAT_CHECK_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      i_rxd;
    logic             i_rklsb, i_rkmsb, i_clr_cnt;
    logic             o_lock, o_valid, o_sof, o_eof, o_frame_err;
    logic [15:0]      o_data;
    logic [CNT_W-1:0] o_frame_cnt, o_err_cnt, o_pat_err_cnt;

    always #5 clk = ~clk;

    tlk2711_rx_frame #(
        .MAX_WORDS (MAX_WORDS),
        .LOCK_CNT  (LOCK_CNT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rxd         (i_rxd),
        .i_rklsb       (i_rklsb),
        .i_rkmsb       (i_rkmsb),
        .i_clr_cnt     (i_clr_cnt),
        .o_lock        (o_lock),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_sof         (o_sof),
        .o_eof         (o_eof),
        .o_frame_err   (o_frame_err),
        .o_frame_cnt   (o_frame_cnt),
        .o_err_cnt     (o_err_cnt),
        .o_pat_err_cnt (o_pat_err_cnt)
    );

    typedef struct packed {
        logic        beat;
        logic [15:0] data;
        logic        sof;
        logic        eof;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] payload[$];
    int          checks   = 0;
    int          failures = 0;
    longint      m_frames = 0;
    longint      m_errs   = 0;
    longint      m_pats   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic chk_counters(input string name);
        chk({name, "_frame_cnt"}, longint'(o_frame_cnt), sat(m_frames));
        chk({name, "_err_cnt"}, longint'(o_err_cnt), sat(m_errs));
        chk({name, "_pat_err_cnt"}, longint'(o_pat_err_cnt), PAT_EN ? sat(m_pats) : 0);
    endtask

    task automatic put(input logic [15:0] w, input logic km, input logic kl, input logic clr);
        @(negedge clk);
        i_rxd     = w;
        i_rkmsb   = km;
        i_rklsb   = kl;
        i_clr_cnt = clr;
    endtask

    task automatic put_idle();                 put(16'hC5BC, 1'b0, 1'b1, 1'b0); endtask
    task automatic put_sof();                  put(16'hFBFB, 1'b1, 1'b1, 1'b0); endtask
    task automatic put_eof();                  put(16'hFDFD, 1'b1, 1'b1, 1'b0); endtask
    task automatic put_bad();                  put(16'hBCBC, 1'b1, 1'b0, 1'b0); endtask
    task automatic put_data(input logic [15:0] d); put(d, 1'b0, 1'b0, 1'b0);   endtask

    task automatic drain();
        repeat (4) put_idle();
    endtask

    task automatic push_err_only();
        exp_t e;
        e     = '0;
        e.err = 1'b1;
        sbq.push_back(e);
    endtask

    // Expected outcome of one frame whose first n payload words get forwarded.
    task automatic expect_frame(input int n, input bit aborted);
        logic [15:0] nxt;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.beat = 1'b1;
            e.data = payload[i];
            e.sof  = (i == 0);
            e.eof  = (i == n - 1);
            e.err  = aborted && (i == n - 1);
            sbq.push_back(e);
            if (i > 0) begin
                nxt = payload[i-1] + 16'd1;
                if (payload[i] != nxt)
                    m_pats++;
            end
        end
        if (n == 0)
            push_err_only();
        if (aborted)
            m_errs++;
        else
            m_frames++;
    endtask

    task automatic gen_payload(input int n);
        logic [15:0] v;
        payload.delete();
        v = 16'($urandom);
        if ($urandom_range(0, 3) == 0)
            v = 16'hFFFC + 16'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            payload.push_back(v);
            if ($urandom_range(0, 7) == 0)
                v = 16'($urandom);
            else
                v = v + 16'd1;
        end
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++)
            put_data(payload[i]);
    endtask

    initial begin : monitor
        exp_t   e;
        longint act, exp;
        forever begin
            @(negedge clk);
            if (o_valid || o_frame_err) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output valid=%0d data=0x%0h sof=%0d eof=%0d err=%0d",
                             o_valid, o_data, o_sof, o_eof, o_frame_err);
                end else begin
                    e   = sbq.pop_front();
                    act = longint'({o_valid, (e.beat ? o_data : 16'h0), o_sof, o_eof, o_frame_err});
                    exp = longint'({e.beat, (e.beat ? e.data : 16'h0), e.sof, e.eof, e.err});
                    chk("beat{valid,data,sof,eof,err}", act, exp);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        i_rxd     = '0;
        i_rklsb   = 1'b0;
        i_rkmsb   = 1'b0;
        i_clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lock", longint'(o_lock), 0);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_flags", longint'({o_sof, o_eof, o_frame_err}), 0);
        chk("rst_data", longint'(o_data), 0);
        chk_counters("rst");
        rst_n = 1'b1;

        // lock acquisition: an interrupted idle run must not lock
        repeat (LOCK_CNT - 1) put_idle();
        put_bad();
        for (int i = 0; i < int'(LOCK_CNT); i++) begin
            put_idle();
            chk("lock_early", longint'(o_lock), 0);
        end
        put_idle();
        chk("lock_acquired", longint'(o_lock), 1);

        payload.delete();
        for (int i = 0; i < 10; i++) payload.push_back(16'(i));
        expect_frame(10, 1'b0);
        put_sof(); send_payload(10); put_eof();
        drain();
        chk_counters("frame_0_9");

        payload.delete();
        for (int i = 0; i < 3; i++) payload.push_back(16'h0100 + 16'(i));
        expect_frame(3, 1'b1);
        put_sof(); send_payload(3); put_idle();
        drain();
        chk_counters("abort_idle");

        payload.delete();
        for (int i = 0; i < int'(MAX_WORDS) + 1; i++) payload.push_back(16'(i));
        expect_frame(int'(MAX_WORDS), 1'b1);
        put_sof(); send_payload(int'(MAX_WORDS) + 1); put_eof();
        drain();
        chk_counters("overflow");

        payload = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8};
        expect_frame(5, 1'b0);
        put_sof(); send_payload(5); put_eof();
        drain();
        chk_counters("pattern");

        for (int f = 0; f < 60; f++) begin
            int kind, n, m;
            kind = $urandom_range(0, 5);
            n    = $urandom_range(0, 12);
            case (kind)
                0: begin
                    if (n == 0) n = 1;
                    gen_payload(n); expect_frame(n, 1'b0);
                    put_sof(); send_payload(n); put_eof();
                end
                1: begin
                    gen_payload(n); expect_frame(n, 1'b1);
                    put_sof(); send_payload(n); put_idle();
                end
                2: begin
                    gen_payload(n); expect_frame(n, 1'b1);
                    put_sof(); send_payload(n); put_bad();
                end
                3: begin
                    payload.delete(); expect_frame(0, 1'b1);
                    put_sof(); put_eof();
                end
                4: begin
                    push_err_only(); m_errs++;
                    if ($urandom_range(0, 1) == 1) put_data(16'($urandom));
                    else put_eof();
                end
                default: begin
                    gen_payload(n); expect_frame(n, 1'b1);
                    put_sof(); send_payload(n);
                    m = $urandom_range(1, 8);
                    gen_payload(m); expect_frame(m, 1'b0);
                    put_sof(); send_payload(m); put_eof();
                end
            endcase
            repeat ($urandom_range(0, 2)) put_idle();
            if ($urandom_range(0, 3) == 0) begin
                put_bad(); put_idle();
            end
        end
        drain();
        chk_counters("random");

        repeat (LOCK_CNT) put_bad();
        put_idle();
        chk("lock_lost", longint'(o_lock), 0);
        repeat (LOCK_CNT - 1) put_idle();
        put_idle();
        chk("lock_regained", longint'(o_lock), 1);

        put(16'hC5BC, 1'b0, 1'b1, 1'b1);
        m_frames = 0; m_errs = 0; m_pats = 0;
        drain();
        chk_counters("clear");

        for (int i = 0; i < int'(CNT_MAX); i++) begin
            push_err_only(); m_errs++; put_eof();
        end
        drain();
        chk_counters("err_at_max");
        push_err_only(); m_errs++; put_eof();
        drain();
        chk_counters("err_saturated");

        push_err_only();
        put(16'hFDFD, 1'b1, 1'b1, 1'b1);
        m_frames = 0; m_errs = 0; m_pats = 0;
        drain();
        chk_counters("clear_beats_incr");

        drain();
        chk("scoreboard_empty", longint'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
